// File: rtl/object_sprite_ctrl.sv
// Sprite position/bounce controller and ROM address generator with 1-cycle output alignment.
// Define OBJ_SCALE2_EN to draw the sprite at 2x (box size, ROM addressing and bounce limits).
module object_sprite_ctrl #(
  parameter int          OBJ_W    = 2,
  parameter int          OBJ_H    = 2,
  parameter int          ROW_W    = 1,
  parameter int          COL_W    = 1,
  parameter int          SCREEN_W = 640,
  parameter int          SCREEN_H = 480,
  parameter int          INIT_X   = 320,
  parameter int          INIT_Y   = 240,
  parameter int          STEP     = 1,
  parameter logic [11:0] TRANSP   = 12'h000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             frame_tick,
  input  logic             video_on,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  output logic [ROW_W-1:0] rom_row,
  output logic [COL_W-1:0] rom_col,
  input  logic [11:0]      rom_color,
  output logic             pixel_on,
  output logic [11:0]      rgb_out,
  output logic [9:0]       obj_x,
  output logic [9:0]       obj_y
);

`ifdef OBJ_SCALE2_EN
  localparam int SCALE_SH = 1;
`else
  localparam int SCALE_SH = 0;
`endif

  localparam int BOX_W = OBJ_W << SCALE_SH;
  localparam int BOX_H = OBJ_H << SCALE_SH;

  localparam logic [10:0] LIM_X  = 11'(SCREEN_W - BOX_W);
  localparam logic [10:0] LIM_Y  = 11'(SCREEN_H - BOX_H);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [9:0]  STEP10 = 10'(STEP);

  // Index 0 is the X axis, index 1 the Y axis.
  localparam logic [1:0][10:0] LIM  = {LIM_Y, LIM_X};
  localparam logic [1:0][9:0]  INIT = {10'(INIT_Y), 10'(INIT_X)};

  typedef enum logic {INC, DEC} dir_t;

  logic move;
  assign move = frame_tick & enable;

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    dir_t        dir_reg, dir_next;
    logic [9:0]  pos_reg, pos_next;
    logic [10:0] pos_ext;

    assign pos_ext = {1'b0, pos_reg};

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pos_reg <= INIT[gi];
        dir_reg <= INC;
      end else begin
        pos_reg <= pos_next;
        dir_reg <= dir_next;
      end
    end

    // Clamp at the edge on the tick that would overshoot, and turn around there.
    always_comb begin
      pos_next = pos_reg;
      dir_next = dir_reg;
      if (move) begin
        unique case (dir_reg)
          INC: begin
            if (pos_ext + STEP11 > LIM[gi]) begin
              pos_next = LIM[gi][9:0];
              dir_next = DEC;
            end else begin
              pos_next = pos_reg + STEP10;
            end
          end
          DEC: begin
            if (pos_ext < STEP11) begin
              pos_next = '0;
              dir_next = INC;
            end else begin
              pos_next = pos_reg - STEP10;
            end
          end
          default: begin
            pos_next = pos_reg;
            dir_next = dir_reg;
          end
        endcase
      end
    end
  end

  assign obj_x = g_axis[0].pos_reg;
  assign obj_y = g_axis[1].pos_reg;

  // Hit test on 11-bit operands; once x >= obj_x the offset cannot wrap,
  // so comparing the offset against the box size is the upper-bound test.
  logic [10:0] x_ext, y_ext, ox_ext, oy_ext, dx, dy;
  logic        in_box;
  logic        in_box_reg;

  assign x_ext  = {1'b0, x};
  assign y_ext  = {1'b0, y};
  assign ox_ext = {1'b0, obj_x};
  assign oy_ext = {1'b0, obj_y};
  assign dx     = x_ext - ox_ext;
  assign dy     = y_ext - oy_ext;

  assign in_box = video_on
                & (x_ext >= ox_ext) & (dx < 11'(BOX_W))
                & (y_ext >= oy_ext) & (dy < 11'(BOX_H));

  assign rom_col = dx[SCALE_SH +: COL_W];
  assign rom_row = dy[SCALE_SH +: ROW_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_box_reg <= 1'b0;
    end else begin
      in_box_reg <= in_box;
    end
  end

  // rom_color already belongs to the previous cycle's address, matching in_box_reg.
  assign pixel_on = in_box_reg & (rom_color != TRANSP);
  assign rgb_out  = pixel_on ? rom_color : 12'h000;

endmodule

// File: tb/tb_object_sprite_ctrl.sv
// Self-checking bench for object_sprite_ctrl: directed vector table, edge-bounce and reset
// sequences, then randomized traffic against a behavioural position/hit model.
module tb_object_sprite_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        frame_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic [0:0]  rom_row;
  logic [0:0]  rom_col;
  logic [11:0] rom_color = '0;
  logic        pixel_on;
  logic [11:0] rgb_out;
  logic [9:0]  obj_x;
  logic [9:0]  obj_y;

  always #5 clk = ~clk;

  object_sprite_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .frame_tick (frame_tick),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .rom_row    (rom_row),
    .rom_col    (rom_col),
    .rom_color  (rom_color),
    .pixel_on   (pixel_on),
    .rgb_out    (rgb_out),
    .obj_x      (obj_x),
    .obj_y      (obj_y)
  );

`ifdef OBJ_SCALE2_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif
  localparam int BW = 2 * SC;
  localparam int BH = 2 * SC;
  localparam int LX = 640 - BW;
  localparam int LY = 480 - BH;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: position, direction (+1/-1), in-box flag of the previous pixel.
  int mx, my, mdx, mdy;
  bit prev_in;

  typedef struct {
    int          px;
    int          py;
    bit          vo;
    logic [11:0] color;
    bit          exp_in;
    int          exp_row;
    int          exp_col;
    bit          exp_pix;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_in(input int px, input int py, input bit vo);
    return vo && (px >= mx) && (px < mx + BW) && (py >= my) && (py < my + BH);
  endfunction

  task automatic model_axis(inout int p, inout int d, input int lim);
    if (d > 0) begin
      if (p + 1 > lim) begin p = lim; d = -1; end
      else p = p + 1;
    end else begin
      if (p < 1) begin p = 0; d = 1; end
      else p = p - 1;
    end
  endtask

  task automatic drive(input int px, input int py, input bit vo, input bit ft,
                       input bit en, input logic [11:0] col);
    x = 10'(px); y = 10'(py); video_on = vo;
    frame_tick = ft; enable = en; rom_color = col;
    #3;
  endtask

  task automatic tick(input bit ft, input bit en);
    @(posedge clk);
    #1;
    if (ft && en) begin
      model_axis(mx, mdx, LX);
      model_axis(my, mdy, LY);
    end
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 12'hFFF);
    repeat (2) @(posedge clk);
    #1;
    check("reset_obj_x", int'(obj_x), 320);
    check("reset_obj_y", int'(obj_y), 240);
    check("reset_pixel_on", int'(pixel_on), 0);
    check("reset_rgb_out", int'(rgb_out), 0);
    reset_n = 1'b1;
    rom_color = '0;
    mx = 320; my = 240; mdx = 1; mdy = 1; prev_in = 0;
  endtask

  // Frame ticks until the model x reaches target moving in direction dir (bounded).
  task automatic run_to(input int target, input int dir);
    int guard = 0;
    while (!(mx == target && mdx == dir) && guard < 3000) begin
      drive(0, 0, 0, 1, 1, 12'h000);
      check("run_obj_x", int'(obj_x), mx);
      check("run_obj_y", int'(obj_y), my);
      tick(1, 1);
      guard++;
    end
    if (guard >= 3000) check("run_to_timeout", guard, 0);
    $display("moved to obj_x=%0d obj_y=%0d after %0d ticks", obj_x, obj_y, guard);
  endtask

  task automatic tick_expect_x(input string name, input int exp);
    drive(0, 0, 0, 1, 1, 12'h000);
    tick(1, 1);
    check(name, int'(obj_x), exp);
    $display("tick %s: obj_x=%0d (want %0d)", name, obj_x, exp);
  endtask

  initial begin
`ifdef OBJ_SCALE2_EN
    vecs[0] = '{323, 242, 1, 12'hFFF, 1, 1, 1, 1, 12'hFFF};
    vecs[1] = '{324, 242, 1, 12'h123, 0, 0, 0, 0, 12'h000};
    vecs[2] = '{320, 240, 1, 12'h000, 1, 0, 0, 0, 12'h000};
    vecs[3] = '{321, 240, 0, 12'hABC, 0, 0, 0, 0, 12'h000};
    vecs[4] = '{319, 240, 1, 12'hABC, 0, 0, 0, 0, 12'h000};
    vecs[5] = '{320, 244, 1, 12'hABC, 0, 0, 0, 0, 12'h000};
    vecs[6] = '{322, 243, 1, 12'h5A5, 1, 1, 1, 1, 12'h5A5};
    vecs[7] = '{321, 241, 1, 12'h00F, 1, 0, 0, 1, 12'h00F};
`else
    vecs[0] = '{321, 241, 1, 12'hFFF, 1, 1, 1, 1, 12'hFFF};
    vecs[1] = '{322, 241, 1, 12'h123, 0, 0, 0, 0, 12'h000};
    vecs[2] = '{320, 240, 1, 12'h000, 1, 0, 0, 0, 12'h000};
    vecs[3] = '{321, 240, 0, 12'hABC, 0, 0, 0, 0, 12'h000};
    vecs[4] = '{319, 240, 1, 12'hABC, 0, 0, 0, 0, 12'h000};
    vecs[5] = '{320, 242, 1, 12'hABC, 0, 0, 0, 0, 12'h000};
    vecs[6] = '{321, 240, 1, 12'h5A5, 1, 0, 1, 1, 12'h5A5};
    vecs[7] = '{320, 241, 1, 12'h00F, 1, 1, 0, 1, 12'h00F};
`endif

    do_reset();

    // Vector table: pixel i is driven in cycle i, its ROM colour and result appear in cycle i+1.
    for (int i = 0; i <= 8; i++) begin
      logic [11:0] col;
      col = (i > 0) ? vecs[i-1].color : 12'h000;
      if (i < 8) drive(vecs[i].px, vecs[i].py, vecs[i].vo, 0, 0, col);
      else       drive(0, 0, 0, 0, 0, col);
      if (i < 8 && vecs[i].exp_in) begin
        check($sformatf("vec%0d_rom_row", i), int'(rom_row), vecs[i].exp_row);
        check($sformatf("vec%0d_rom_col", i), int'(rom_col), vecs[i].exp_col);
      end
      if (i > 0) begin
        check($sformatf("vec%0d_pixel_on", i-1), int'(pixel_on), int'(vecs[i-1].exp_pix));
        check($sformatf("vec%0d_rgb_out", i-1), int'(rgb_out), int'(vecs[i-1].exp_rgb));
        $display("vec%0d: x=%0d y=%0d pixel_on=%0d rgb_out=%03h", i-1,
                 vecs[i-1].px, vecs[i-1].py, pixel_on, rgb_out);
      end
      tick(0, 0);
    end

    // Reset in the middle of a line clears the output immediately.
    drive(321, 241, 1, 0, 0, 12'h000);
    tick(0, 0);
    drive(0, 0, 0, 0, 0, 12'hFFF);
    check("midreset_pre_pixel_on", int'(pixel_on), 1);
    reset_n = 1'b0;
    #1;
    check("midreset_pixel_on", int'(pixel_on), 0);
    check("midreset_rgb_out", int'(rgb_out), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(320, 240, 1, 0, 0, 12'hFFF);
    check("postreset_first_pixel_on", int'(pixel_on), 0);
    tick(0, 0);
    drive(0, 0, 0, 0, 0, 12'hFFF);
    check("postreset_next_pixel_on", int'(pixel_on), 1);
    $display("mid-line reset: pixel_on=%0d rgb_out=%03h", pixel_on, rgb_out);
    tick(0, 0);

    // Freeze: frame ticks with enable low change nothing, one enabled tick moves both axes.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 12'h000);
      tick(1, 0);
      check("freeze_obj_x", int'(obj_x), 320);
      check("freeze_obj_y", int'(obj_y), 240);
    end
    drive(0, 0, 0, 1, 1, 12'h000);
    tick(1, 1);
    check("unfreeze_obj_x", int'(obj_x), 321);
    check("unfreeze_obj_y", int'(obj_y), 241);
    $display("freeze: obj_x=%0d obj_y=%0d", obj_x, obj_y);

    // Right-edge then left-edge bounce.
    run_to(LX - 1, 1);
    tick_expect_x("right_reach", LX);
    tick_expect_x("right_flip", LX);
    tick_expect_x("right_back", LX - 1);
    run_to(1, -1);
    tick_expect_x("left_reach", 0);
    tick_expect_x("left_flip", 0);
    tick_expect_x("left_back", 1);

    // Randomized traffic against the model.
    prev_in = 0;
    for (int i = 0; i < 1500; i++) begin
      int px, py;
      bit vo, ft, en, cur_in, exp_pix;
      logic [11:0] col;
      px = mx + int'($urandom_range(0, BW + 5)) - 3;
      py = my + int'($urandom_range(0, BH + 5)) - 3;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      vo = ($urandom_range(0, 3) != 0);
      ft = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 3) != 0);
      col = ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom);
      drive(px, py, vo, ft, en, col);
      exp_pix = prev_in && (col != 12'h000);
      check("rand_pixel_on", int'(pixel_on), int'(exp_pix));
      check("rand_rgb_out", int'(rgb_out), exp_pix ? int'(col) : 0);
      check("rand_obj_x", int'(obj_x), mx);
      check("rand_obj_y", int'(obj_y), my);
      cur_in = model_in(px, py, vo);
      if (cur_in) begin
        check("rand_rom_row", int'(rom_row), ((py - my) / SC) % 2);
        check("rand_rom_col", int'(rom_col), ((px - mx) / SC) % 2);
      end
      tick(ft, en);
      prev_in = cur_in;
    end
    $display("random: 1500 cycles, final obj_x=%0d obj_y=%0d", obj_x, obj_y);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
